// File: rtl/mul_arb_pkg.sv
// Shared types, sizing constants and the hidden-bit fraction multiplier for mul_arb_2req.
// Build option MUL_ARB_STATS_EN (used by mul_arb_2req) adds per-requester grant counters.
package mul_arb_pkg;

  localparam int N_REQ  = 2;
  localparam int OP_W   = 12;
  localparam int RES_W  = 12;
  localparam int FRAC_W = 5;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic              left_neg;
    logic              right_neg;
    logic [FRAC_W-1:0] left_frac;
    logic [FRAC_W-1:0] right_frac;
  } op_t;

  // Each operand is 1.frac (hidden one). The product lies in [1,4); when it
  // reaches 2 the result is shifted right one place and exp_augment is set.
  function automatic logic [RES_W-1:0] frac_mul(input op_t op);
    logic [FRAC_W:0]  w_ma;
    logic [FRAC_W:0]  w_mb;
    logic [11:0]      w_prod;
    logic             w_aug;
    logic [9:0]       w_frac;
    w_ma   = {1'b1, op.left_frac};
    w_mb   = {1'b1, op.right_frac};
    w_prod = {6'b0, w_ma} * {6'b0, w_mb};
    w_aug  = w_prod[11];
    w_frac = w_aug ? w_prod[10:1] : w_prod[9:0];
    return {op.left_neg ^ op.right_neg, w_aug, w_frac};
  endfunction

endpackage

// File: rtl/mul_arb_rr2.sv
// Two-way round-robin picker: a lone requester wins, on contention the one
// that did not win last time (the one not equal to ptr) wins.
module mul_arb_rr2
  import mul_arb_pkg::*;
(
  input  logic [N_REQ-1:0] valid,
  input  logic             ptr,
  input  logic             enable,
  output logic [N_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
  end

endmodule

// File: rtl/mul_arb_2req.sv
// Two requesters share one fraction multiplier through a 2-stage valid/ready pipeline.
// Define MUL_ARB_STATS_EN to add the saturating per-requester grant_cnt output.
module mul_arb_2req
  import mul_arb_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0][OP_W-1:0]  req_op,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [RES_W-1:0]            out_result,
  output logic                        out_tag,
  output logic                        busy
`ifdef MUL_ARB_STATS_EN
  ,
  output logic [N_REQ-1:0][CNT_W-1:0] grant_cnt
`endif
);

  logic             r_s1_valid;
  op_t              r_s1_op;
  logic             r_s1_tag;
  logic             r_s2_valid;
  logic [RES_W-1:0] r_s2_result;
  logic             r_s2_tag;
  logic             r_ptr;

  logic             w_advance;
  logic             w_s1_load;
  logic [N_REQ-1:0] w_grant;
  logic             w_accept;
  logic             w_idx;

  assign w_advance = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_advance;

  mul_arb_rr2 u_rr (
    .valid  (req_valid),
    .ptr    (r_ptr),
    .enable (w_s1_load),
    .grant  (w_grant)
  );

  assign w_accept = |w_grant;
  assign w_idx    = w_grant[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_op     <= '0;
      r_s1_tag    <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_tag    <= 1'b0;
      r_ptr       <= 1'b1;
    end else begin
      if (w_advance) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_result <= frac_mul(r_s1_op);
          r_s2_tag    <= r_s1_tag;
        end
      end
      if (w_s1_load) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_op  <= op_t'(req_op[w_idx]);
          r_s1_tag <= w_idx;
          r_ptr    <= w_idx;
        end
      end
    end
  end

  assign req_ready  = w_grant;
  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_tag    = r_s2_tag;
  assign busy       = r_s1_valid || r_s2_valid;

`ifdef MUL_ARB_STATS_EN
  logic [N_REQ-1:0][CNT_W-1:0] r_grant_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_grant[i] && (r_grant_cnt[i] != {CNT_W{1'b1}})) begin
          r_grant_cnt[i] <= r_grant_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign grant_cnt = r_grant_cnt;
`endif

endmodule
